// File: rtl/board_scanner.sv
// Board cell store with a ready/valid scanner that streams every cell once per
// start request and tallies hit and ship cells over the scan.
module board_scanner #(
  parameter int CELLS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [1:0]    out_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   hit_count,
  output logic [AW:0]   ship_count
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(CELLS - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  state_t        state, state_nxt;
  logic [1:0]    mem [CELLS];
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic [1:0]    first_data;
  logic          load, xfer, last;

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign out_addr = idx;
  assign load     = (state == IDLE) && start;
  assign xfer     = (state == SCAN) && out_valid && out_ready;
  assign last     = (idx == LAST_IDX);
  assign idx_nxt  = idx + IDX_ONE;

  // A write landing in the same cycle as start must be visible to cell 0.
  assign first_data = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (xfer && last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Writes are locked out for the whole scan so the board stays frozen.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= 2'b00;
    end else if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx        <= '0;
      out_valid  <= 1'b0;
      out_data   <= 2'b00;
      hit_count  <= '0;
      ship_count <= '0;
    end else if (load) begin
      idx        <= '0;
      out_valid  <= 1'b1;
      out_data   <= first_data;
      hit_count  <= '0;
      ship_count <= '0;
    end else if (xfer) begin
      if (out_data == 2'b10) hit_count  <= hit_count + CNT_ONE;
      if (out_data == 2'b01) ship_count <= ship_count + CNT_ONE;
      if (last) begin
        out_valid <= 1'b0;
      end else begin
        idx      <= idx_nxt;
        out_data <= mem[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: reset, full scans, stalls, frozen writes,
// ignored start, mid-scan reset and full-count boundary.
module tb_board_scanner;

  logic       clk, clr, wr_en, start, out_ready;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  logic       out_valid, busy, done;
  logic [3:0] out_addr;
  logic [1:0] out_data;
  logic [4:0] hit_count, ship_count;

  int cmp_n = 0;
  int bad_n = 0;

  logic [1:0] exp_mem [16];
  int         xfer_n, done_cyc, done_n, first_valid_cyc;
  logic [3:0] x_addr [64];
  logic [1:0] x_data [64];
  bit         stall_bad;
  logic       busy_after;

  board_scanner #(.CELLS(16), .AW(4)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .out_ready(out_ready), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
    .hit_count(hit_count), .ship_count(ship_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int count_code(input logic [1:0] code);
    int n = 0;
    for (int i = 0; i < 16; i++) if (exp_mem[i] == code) n++;
    return n;
  endfunction

  task automatic write_cell(input logic [3:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    exp_mem[a] = d;
  endtask

  // Runs one scan and records what the DUT presented; tests judge the record.
  task automatic run_scan(input int mode, input int start_at, input bit start_fin,
                          input int wr_at, input bit cw, input logic [3:0] cw_a,
                          input logic [1:0] cw_d);
    int         cyc;
    bit         prev_stall, exit_now;
    logic [3:0] prev_addr;
    logic [1:0] prev_data;
    xfer_n = 0; done_cyc = -1; done_n = 0; first_valid_cyc = -1;
    stall_bad = 0; prev_stall = 0; prev_addr = '0; prev_data = '0; cyc = 0;
    start = 1'b1;
    if (cw) begin
      wr_en = 1'b1; wr_addr = cw_a; wr_data = cw_d; exp_mem[cw_a] = cw_d;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    forever begin
      cyc++;
      if (cyc > 200) begin
        cmp_n++; bad_n++;
        $display("FAIL scan_timeout: no done after %0d cycles, required done", cyc);
        break;
      end
      if (prev_stall && (!out_valid || out_addr !== prev_addr || out_data !== prev_data))
        stall_bad = 1;
      out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      wr_en = (cyc == wr_at); wr_addr = 4'd7; wr_data = 2'b10;
      start = (cyc == start_at);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        start = start_fin;
      end
      if (out_valid && out_ready && xfer_n < 64) begin
        x_addr[xfer_n] = out_addr; x_data[xfer_n] = out_data; xfer_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_addr = out_addr; prev_data = out_data;
      exit_now = done;
      @(posedge clk); #1;
      if (exit_now) break;
    end
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    busy_after = busy;
    if (done) done_n++;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    #2 clr = 1'b0;
    #1;
    cmp_n++; if (out_valid !== 1'b0) begin bad_n++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp_n++; if (done !== 1'b0) begin bad_n++; $display("FAIL rst_done: got %b want 0", done); end
    cmp_n++; if (out_addr !== 4'd0) begin bad_n++; $display("FAIL rst_addr: got %0d want 0", out_addr); end
    cmp_n++; if (out_data !== 2'b00) begin bad_n++; $display("FAIL rst_data: got %b want 00", out_data); end
    cmp_n++; if (hit_count !== 5'd0) begin bad_n++; $display("FAIL rst_hit: got %0d want 0", hit_count); end
    cmp_n++; if (ship_count !== 5'd0) begin bad_n++; $display("FAIL rst_ship: got %0d want 0", ship_count); end
    @(posedge clk); #1;
    clr = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
  endtask

  task automatic test_basic_scan;
    int errs = 0;
    write_cell(4'd3, 2'b01);
    write_cell(4'd5, 2'b10);
    write_cell(4'd9, 2'b10);
    write_cell(4'd15, 2'b11);
    run_scan(0, -1, 0, -1, 0, 4'd0, 2'b00);
    cmp_n++; if (first_valid_cyc != 1) begin bad_n++; $display("FAIL basic_latency: got %0d want 1", first_valid_cyc); end
    cmp_n++; if (xfer_n != 16) begin bad_n++; $display("FAIL basic_xfers: got %0d want 16", xfer_n); end
    for (int i = 0; i < 16 && i < xfer_n; i++)
      if (x_addr[i] !== 4'(i) || x_data[i] !== exp_mem[i]) errs++;
    cmp_n++; if (errs != 0) begin bad_n++; $display("FAIL basic_cells: got %0d bad cells want 0", errs); end
    cmp_n++; if (done_cyc != 17) begin bad_n++; $display("FAIL basic_done_cycle: got %0d want 17", done_cyc); end
    cmp_n++; if (hit_count !== 5'd2) begin bad_n++; $display("FAIL basic_hit: got %0d want 2", hit_count); end
    cmp_n++; if (ship_count !== 5'd1) begin bad_n++; $display("FAIL basic_ship: got %0d want 1", ship_count); end
    cmp_n++; if (busy_after !== 1'b0 || done_n != 1) begin bad_n++; $display("FAIL basic_finish: busy %b dones %0d want 0 and 1", busy_after, done_n); end
  endtask

  task automatic test_stall;
    int errs = 0;
    run_scan(1, -1, 0, -1, 0, 4'd0, 2'b00);
    cmp_n++; if (xfer_n != 16) begin bad_n++; $display("FAIL stall_xfers: got %0d want 16", xfer_n); end
    for (int i = 0; i < 16 && i < xfer_n; i++)
      if (x_addr[i] !== 4'(i) || x_data[i] !== exp_mem[i]) errs++;
    cmp_n++; if (errs != 0) begin bad_n++; $display("FAIL stall_order: got %0d bad cells want 0", errs); end
    cmp_n++; if (stall_bad) begin bad_n++; $display("FAIL stall_stable: got unstable want stable"); end
    cmp_n++; if (done_cyc != 33) begin bad_n++; $display("FAIL stall_done_cycle: got %0d want 33", done_cyc); end
    cmp_n++; if (hit_count !== 5'd2 || ship_count !== 5'd1) begin bad_n++; $display("FAIL stall_counts: got %0d/%0d want 2/1", hit_count, ship_count); end
  endtask

  task automatic test_write_while_busy;
    run_scan(0, -1, 0, 3, 0, 4'd0, 2'b00);
    cmp_n++; if (xfer_n < 8 || x_data[7] !== 2'b00) begin bad_n++; $display("FAIL busywr_same_scan: got %b want 00", x_data[7]); end
    run_scan(0, -1, 0, -1, 0, 4'd0, 2'b00);
    cmp_n++; if (xfer_n < 8 || x_data[7] !== exp_mem[7]) begin bad_n++; $display("FAIL busywr_rescan: got %b want %b", x_data[7], exp_mem[7]); end
    cmp_n++; if (hit_count !== 5'(count_code(2'b10))) begin bad_n++; $display("FAIL busywr_hit: got %0d want %0d", hit_count, count_code(2'b10)); end
  endtask

  task automatic test_start_during_scan;
    int idle_bad = 0;
    run_scan(0, 5, 1, -1, 0, 4'd0, 2'b00);
    cmp_n++; if (xfer_n != 16) begin bad_n++; $display("FAIL dupstart_xfers: got %0d want 16", xfer_n); end
    cmp_n++; if (busy_after !== 1'b0) begin bad_n++; $display("FAIL dupstart_busy: got %b want 0", busy_after); end
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || out_valid !== 1'b0) idle_bad++;
      if (done === 1'b1) done_n++;
      @(posedge clk); #1;
    end
    cmp_n++; if (idle_bad != 0) begin bad_n++; $display("FAIL dupstart_idle: got %0d busy cycles want 0", idle_bad); end
    cmp_n++; if (done_n != 1) begin bad_n++; $display("FAIL dupstart_dones: got %0d want 1", done_n); end
  endtask

  task automatic test_reset_mid_scan;
    int n = 0, dn = 0, errs = 0;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(out_valid && out_addr == 4'd6) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    cmp_n++; if (n >= 40) begin bad_n++; $display("FAIL midrst_reach: got no addr 6 want addr 6"); end
    cmp_n++; if (hit_count !== 5'd1 || ship_count !== 5'd1) begin bad_n++; $display("FAIL midrst_pre_counts: got %0d/%0d want 1/1", hit_count, ship_count); end
    clr = 1'b0;
    #1;
    cmp_n++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad_n++; $display("FAIL midrst_ctrl: got v%b b%b d%b want 000", out_valid, busy, done); end
    cmp_n++; if (out_addr !== 4'd0 || out_data !== 2'b00) begin bad_n++; $display("FAIL midrst_out: got %0d/%b want 0/00", out_addr, out_data); end
    cmp_n++; if (hit_count !== 5'd0 || ship_count !== 5'd0) begin bad_n++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", hit_count, ship_count); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    out_ready = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    cmp_n++; if (dn != 0) begin bad_n++; $display("FAIL midrst_no_done: got %0d pulses want 0", dn); end
    run_scan(0, -1, 0, -1, 0, 4'd0, 2'b00);
    for (int i = 0; i < 16 && i < xfer_n; i++) if (x_data[i] !== 2'b00) errs++;
    cmp_n++; if (xfer_n != 16 || errs != 0) begin bad_n++; $display("FAIL midrst_rescan: got %0d xfers %0d nonzero want 16 and 0", xfer_n, errs); end
    cmp_n++; if (hit_count !== 5'd0 || ship_count !== 5'd0) begin bad_n++; $display("FAIL midrst_rescan_counts: got %0d/%0d want 0/0", hit_count, ship_count); end
  endtask

  task automatic test_all_hits;
    for (int i = 1; i < 16; i++) write_cell(4'(i), 2'b10);
    run_scan(0, -1, 0, -1, 1, 4'd0, 2'b10);
    cmp_n++; if (xfer_n < 1 || x_data[0] !== 2'b10) begin bad_n++; $display("FAIL allhit_same_cycle_write: got %b want 10", x_data[0]); end
    cmp_n++; if (hit_count !== 5'b10000) begin bad_n++; $display("FAIL allhit_hit: got %b want 10000", hit_count); end
    cmp_n++; if (ship_count !== 5'd0) begin bad_n++; $display("FAIL allhit_ship: got %0d want 0", ship_count); end
    @(posedge clk); #1;
    cmp_n++; if (hit_count !== 5'b10000) begin bad_n++; $display("FAIL allhit_hold: got %b want 10000", hit_count); end
  endtask

  initial begin
    clr = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    test_reset;
    test_basic_scan;
    test_stall;
    test_write_while_busy;
    test_start_during_scan;
    test_reset_mid_scan;
    test_all_hits;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 The module SHALL have parameter CELLS, default 16, giving the number of board cells (power of two, 4..64).
REQ-002 The module SHALL have parameter AW, default 4, giving the address width, equal to log2(CELLS).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 clr  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  cell write strobe.
REQ-006 wr_addr  input  AW  cell index to write.
REQ-007 wr_data  input  2  cell code: 00 empty, 01 ship, 10 hit, 11 miss.
REQ-008 start  input  1  request a full board scan.
REQ-009 out_ready  input  1  downstream accepts the current cell.
REQ-010 out_valid  output  1  out_addr/out_data hold a valid cell.
REQ-011 out_addr  output  AW  index of the presented cell.
REQ-012 out_data  output  2  code of the presented cell.
REQ-013 busy  output  1  high while a scan is in progress.
REQ-014 done  output  1  one-cycle pulse at scan completion.
REQ-015 hit_count  output  AW+1  number of cells coded 10 in the last scan.
REQ-016 ship_count  output  AW+1  number of cells coded 01 in the last scan.

Function
REQ-017 Storage SHALL be CELLS entries of 2 bits; a write with wr_en=1 while busy=0 SHALL update mem[wr_addr] at the clock edge.
REQ-018 Writes with wr_en=1 while busy=1 SHALL be ignored, so board contents stay frozen for the whole scan.
REQ-019 The FSM SHALL have exactly three states: IDLE, SCAN, FINISH.
REQ-020 In IDLE, start=1 SHALL cause a move to SCAN, set the index to 0, and clear hit_count and ship_count to 0.
REQ-021 Latency: with start sampled high at edge n, out_valid=1 and out_addr=0 SHALL hold from edge n+1.
REQ-022 In SCAN, busy=1 and out_valid=1 SHALL hold, with out_addr=index and out_data=mem[index] from registered outputs.
REQ-023 While out_valid=1 and out_ready=0, out_addr and out_data SHALL remain stable.
REQ-024 At a transfer (out_valid and out_ready both 1), hit_count SHALL increment if out_data=10 and ship_count SHALL increment if out_data=01.
REQ-025 At a transfer with index below CELLS-1, the index SHALL increment and the next cell SHALL be presented in the following cycle with out_valid held high.
REQ-026 At a transfer with index equal to CELLS-1, the FSM SHALL go to FINISH and out_valid SHALL deassert at that edge.
REQ-027 FINISH SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-028 In IDLE, busy, done and out_valid SHALL be 0, and hit_count and ship_count SHALL hold their last-scan values.
REQ-029 start=1 while in SCAN or FINISH SHALL be ignored and SHALL NOT be queued.
REQ-030 A cell write and start asserted in the same IDLE cycle SHALL both be honoured, and the scan SHALL see the newly written value.
REQ-031 The counts SHALL never overflow: each width is AW+1 bits and the maximum count is CELLS.
REQ-032 With out_ready held at 1, a full scan SHALL take exactly CELLS+1 cycles from the first out_valid to done.

Reset
REQ-033 clr=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, the index to 0, all mem entries to 00, and out_valid, out_addr, out_data, busy, done, hit_count and ship_count to 0.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-035 After clr returns to 1, the module SHALL accept writes and start on the next rising edge.

Verification
REQ-036 Write cells 3=01, 5=10, 9=10, 15=11, pulse start, out_ready=1 -> 16 transfers with addr 0..15 and matching data; done at cycle 17; hit_count=2, ship_count=1.
REQ-037 Scan with out_ready toggled 0/1 each cycle -> addr/data stable during stalls, no cell skipped or repeated, done after 16 transfers.
REQ-038 wr_en=1 to cell 7 with data 10 while busy -> write ignored; a following scan reports cell 7 unchanged.
REQ-039 start pulsed during SCAN -> exactly one done pulse, busy drops after FINISH, no second scan.
REQ-040 clr=0 at addr 6 mid-scan -> outputs 0 immediately; a rescan reports all cells 00 and counts 0.
REQ-041 All 16 cells written 10 -> hit_count=16 (10000b), ship_count=0, no wrap.
